pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have port Clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port Start, input, 1 bit: program-start request from the test bench or top level.
REQ-004 The block SHALL have port StartAddr, input, 10 bits: first instruction address of the program to run.
REQ-005 The block SHALL have port Halt, input, 1 bit: decoded halt instruction at the current ProgCtr.
REQ-006 The block SHALL have port BranchEn, input, 1 bit: decoded bnzl instruction at the current ProgCtr.
REQ-007 The block SHALL have port Zero, input, 1 bit: ALU zero flag for the current cycle.
REQ-008 The block SHALL have port TargetSel, input, 4 bits: branch-table index field of the current instruction.
REQ-009 The block SHALL have port LutIndex, output, 4 bits: index driven to the branch-offset lookup table.
REQ-010 The block SHALL have port LutOut, input, 11 bits: signed two's-complement offset returned by the lookup table.
REQ-011 The block SHALL have port ProgCtr, output, 10 bits: current instruction address.
REQ-012 The block SHALL have port Running, output, 1 bit: high while in state RUN.
REQ-013 The block SHALL have port Ack, output, 1 bit: program-complete indication.
REQ-014 The block SHALL have port InstrCount, output, 16 bits: number of RUN cycles since the last program start.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE. Running = (state==RUN) and Ack = (state==DONE); both are registered-state decodes.
REQ-016 LutIndex SHALL equal TargetSel combinationally in all states, with zero latency.
REQ-017 In IDLE with Start=1, the next state SHALL be RUN, with ProgCtr <= StartAddr and InstrCount <= 0. In IDLE with Start=0, all state SHALL hold.
REQ-018 In RUN, InstrCount SHALL increment by 1 every cycle and saturate at 16'hFFFF (no wrap).
REQ-019 In RUN with Halt=1, the next state SHALL be DONE and ProgCtr SHALL hold. Halt has priority over BranchEn in the same cycle.
REQ-020 In RUN with Halt=0, BranchEn=1 and Zero=0 (branch taken), the next ProgCtr SHALL be ProgCtr + sign-extended LutOut, truncated to 10 bits (modulo 1024).
REQ-021 In RUN with Halt=0 and the branch not taken (BranchEn=0, or Zero=1), the next ProgCtr SHALL be ProgCtr+1 modulo 1024, so 1023 wraps to 0.
REQ-022 A taken branch with LutOut=0 SHALL hold ProgCtr (self-loop); this is legal and is not treated as a halt.
REQ-023 Start SHALL be ignored in RUN; StartAddr SHALL be sampled only on the IDLE->RUN transition.
REQ-024 In DONE, ProgCtr and InstrCount SHALL hold. The block SHALL move to IDLE on the first cycle with Start=0 and stay in DONE while Start=1, so Ack is level-held until Start is released.
REQ-025 Halt, BranchEn, Zero and LutOut SHALL be ignored in IDLE and DONE.
REQ-026 The next-PC path SHALL be one cycle: a branch decision in cycle N appears on ProgCtr in cycle N+1.

Reset
REQ-027 When Reset=1 at a rising Clk edge, the block SHALL enter IDLE with ProgCtr=0 and InstrCount=0; Running=0 and Ack=0 follow from the IDLE state.
REQ-028 Reset SHALL override every other input, including Start and Halt in the same cycle, and SHALL abort a program mid-RUN with no Ack pulse.
REQ-029 After Reset deasserts, a Start that is still held high SHALL start a new program on the first non-reset edge.

Verification
REQ-030 Bench SHALL cover: StartAddr=400, Start pulse, three non-branch cycles -> ProgCtr 400,401,402,403, and InstrCount=3 after the third RUN cycle.
REQ-031 Bench SHALL cover: ProgCtr=400, BranchEn=1, Zero=0, LutOut=-370 -> next ProgCtr=30. The same case with Zero=1 -> next ProgCtr=401.
REQ-032 Bench SHALL cover: ProgCtr=1023 with no branch -> ProgCtr=0. ProgCtr=5 with taken branch and LutOut=-447 -> ProgCtr=582.
REQ-033 Bench SHALL cover: Halt=1 and BranchEn=1 (Zero=0) in the same cycle -> state DONE, ProgCtr unchanged, Ack=1 held while Start=1, then IDLE and Ack=0 one cycle after Start drops.
REQ-034 Bench SHALL cover: Reset asserted in RUN at ProgCtr=200 -> next cycle IDLE, ProgCtr=0, InstrCount=0, Running=0, Ack never asserted.
REQ-035 Bench SHALL cover: 70000 RUN cycles without Halt -> InstrCount=65535, held.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE control with a branch-offset next-PC path.
// Registered outputs, one-cycle next-PC latency; no backpressure, Ack held until Start drops.
module pc_sequencer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [9:0]  StartAddr,
  input  logic        Halt,
  input  logic        BranchEn,
  input  logic        Zero,
  input  logic [3:0]  TargetSel,
  output logic [3:0]  LutIndex,
  input  logic [10:0] LutOut,
  output logic [9:0]  ProgCtr,
  output logic        Running,
  output logic        Ack,
  output logic [15:0] InstrCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [9:0]  pc_nxt;
  logic [15:0] cnt_nxt;
  logic        branch_taken;

  assign LutIndex     = TargetSel;
  assign branch_taken = BranchEn && !Zero;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      ProgCtr    <= '0;
      InstrCount <= '0;
    end else begin
      state      <= state_nxt;
      ProgCtr    <= pc_nxt;
      InstrCount <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = ProgCtr;
    cnt_nxt   = InstrCount;
    unique case (state)
      IDLE: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = StartAddr;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        cnt_nxt = (InstrCount == 16'hFFFF) ? InstrCount : InstrCount + 16'd1;
        if (Halt) begin
          state_nxt = DONE;
        end else if (branch_taken) begin
          // 11-bit add then drop the top bit: same as sign-extend and wrap mod 1024
          pc_nxt = 10'({1'b0, ProgCtr} + LutOut);
        end else begin
          pc_nxt = ProgCtr + 10'd1;
        end
      end
      DONE: begin
        if (!Start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Running = (state == RUN);
    Ack     = (state == DONE);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed corner programs plus random traffic against an arithmetic model.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Start, Halt, BranchEn, Zero;
  logic [9:0]  StartAddr;
  logic [3:0]  TargetSel, LutIndex;
  logic [10:0] LutOut;
  logic [9:0]  ProgCtr;
  logic        Running, Ack;
  logic [15:0] InstrCount;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // model: mode 0 = idle, 1 = running, 2 = done
  int m_mode = 0;
  int m_pc   = 0;
  int m_cnt  = 0;
  bit ack_seen;

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .Halt(Halt), .BranchEn(BranchEn), .Zero(Zero), .TargetSel(TargetSel),
    .LutIndex(LutIndex), .LutOut(LutOut), .ProgCtr(ProgCtr),
    .Running(Running), .Ack(Ack), .InstrCount(InstrCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    Reset = 0; Start = 0; Halt = 0; BranchEn = 0; Zero = 0;
    TargetSel = '0; LutOut = '0;
  endtask

  // Advance one clock, update the model from the inputs presented, optionally compare.
  task automatic step(input bit do_chk);
    int n_mode, n_pc, n_cnt, off;
    n_mode = m_mode; n_pc = m_pc; n_cnt = m_cnt;
    off = $signed(LutOut);
    if (Reset) begin
      n_mode = 0; n_pc = 0; n_cnt = 0;
    end else if (m_mode == 0) begin
      if (Start) begin n_mode = 1; n_pc = StartAddr; n_cnt = 0; end
    end else if (m_mode == 1) begin
      n_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (Halt)                  n_mode = 2;
      else if (BranchEn && !Zero) n_pc = (((m_pc + off) % 1024) + 1024) % 1024;
      else                       n_pc = (m_pc + 1) % 1024;
    end else if (!Start) begin
      n_mode = 0;
    end
    @(posedge Clk);
    #1;
    m_mode = n_mode; m_pc = n_pc; m_cnt = n_cnt;
    ack_seen |= Ack;
    if (do_chk) begin
      chk("pc",      ProgCtr,    m_pc);
      chk("count",   InstrCount, m_cnt);
      chk("running", Running,    (m_mode == 1));
      chk("ack",     Ack,        (m_mode == 2));
      chk("lutidx",  LutIndex,   TargetSel);
    end
  endtask

  // Reset with Start held, so the first non-reset edge launches the program.
  task automatic launch(input int addr);
    idle_inputs();
    Reset = 1; Start = 1; StartAddr = 10'(addr);
    step(1);
    Reset = 0;
    step(1);
    Start = 0;
  endtask

  initial begin
    idle_inputs();
    StartAddr = '0;
    Reset = 1;
    step(1);
    chk("rst_pc", ProgCtr, 0);
    chk("rst_cnt", InstrCount, 0);
    chk("rst_run", Running, 0);
    Reset = 0;
    step(1);

    // sequential fetch from 400
    launch(400);
    chk("seq_start", ProgCtr, 400);
    for (int i = 1; i <= 3; i++) begin
      step(1);
      chk("seq_pc", ProgCtr, 400 + i);
    end
    chk("seq_cnt3", InstrCount, 3);

    // taken branch backwards, then same setup not taken
    launch(400);
    BranchEn = 1; Zero = 0; LutOut = 11'(-370);
    step(1);
    chk("br_taken", ProgCtr, 30);
    launch(400);
    BranchEn = 1; Zero = 1; LutOut = 11'(-370);
    step(1);
    chk("br_zero", ProgCtr, 401);

    // wrap and large negative offset
    launch(1023);
    step(1);
    chk("wrap", ProgCtr, 0);
    launch(5);
    BranchEn = 1; LutOut = 11'(-447);
    step(1);
    chk("br_neg", ProgCtr, 582);

    // self-loop on zero offset
    BranchEn = 1; Zero = 0; LutOut = '0;
    step(1);
    chk("selfloop_pc", ProgCtr, 582);
    chk("selfloop_run", Running, 1);

    // halt beats branch; Ack held while Start stays high
    launch(100);
    Halt = 1; BranchEn = 1; Zero = 0; LutOut = 11'd50; Start = 1;
    step(1);
    chk("halt_pc", ProgCtr, 100);
    chk("halt_ack", Ack, 1);
    Halt = 0;
    step(1);
    step(1);
    chk("ack_held", Ack, 1);
    Start = 0;
    step(1);
    chk("ack_drop", Ack, 0);
    chk("ack_pc", ProgCtr, 100);

    // reset aborts mid-run without Ack
    launch(190);
    ack_seen = 0;
    for (int i = 0; i < 10; i++) step(1);
    chk("abort_pc200", ProgCtr, 200);
    Reset = 1; Halt = 1;
    step(1);
    Reset = 0; Halt = 0;
    chk("abort_pc", ProgCtr, 0);
    chk("abort_cnt", InstrCount, 0);
    chk("abort_run", Running, 0);
    step(1);
    chk("abort_noack", ack_seen, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      Reset     = ($urandom_range(0, 99) == 0);
      Start     = ($urandom_range(0, 3) == 0);
      StartAddr = 10'($urandom);
      Halt      = ($urandom_range(0, 24) == 0);
      BranchEn  = $urandom_range(0, 1);
      Zero      = $urandom_range(0, 1);
      TargetSel = 4'($urandom);
      LutOut    = 11'($urandom);
      step(1);
    end

    // counter saturation
    launch(0);
    for (int i = 0; i < 70000; i++) begin
      BranchEn  = $urandom_range(0, 1);
      Zero      = $urandom_range(0, 1);
      LutOut    = 11'($urandom);
      TargetSel = 4'($urandom);
      step((i % 8192) == 0);
    end
    chk("sat_cnt", InstrCount, 65535);
    step(1);
    step(1);
    chk("sat_hold", InstrCount, 65535);
    chk("sat_run", Running, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
